// File: rtl/nipcb_spi_master.sv
// 3-wire mode-0 SPI master for one NI PCB: HP DAC write frames and ADC read frames on shared sclk/sdio.
// One command per frame via valid/ready; all outputs registered; ADC word returned on a one-cycle rsp_valid.
module nipcb_spi_master #(
  parameter int CLK_DIV      = 4,
  parameter int DAC_BITS     = 24,
  parameter int ADC_BITS     = 16,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_target,
  input  logic [DAC_BITS-1:0] cmd_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                busy,
  output logic                ni_csn_hp_dac,
  output logic                ni_csn_adc,
  output logic                ni_sclk,
  output logic                sdio_o,
  output logic                sdio_oe,
  input  logic                sdio_i
);

  localparam int MAX_SH   = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int MAX_CYC  = (CLK_DIV > MAX_SH) ? CLK_DIV : MAX_SH;
  localparam int CW       = $clog2(MAX_CYC + 1);
  localparam int MAX_BITS = (DAC_BITS > ADC_BITS) ? DAC_BITS : ADC_BITS;
  localparam int BW       = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                tgt_q, tgt_d;
  logic [DAC_BITS-1:0] wsr_q, wsr_d;
  logic [ADC_BITS-1:0] rsr_q, rsr_d;
  logic                sclk_q, sclk_d;
  logic                sdio_o_q, sdio_o_d;
  logic                sdio_oe_q, sdio_oe_d;
  logic                csn_dac_q, csn_dac_d;
  logic                csn_adc_q, csn_adc_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                last_bit;

  // Frame length depends on the latched target, not on the live command inputs.
  assign last_bit = tgt_q ? (bit_q == BW'(ADC_BITS - 1)) : (bit_q == BW'(DAC_BITS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tgt_d       = tgt_q;
    wsr_d       = wsr_q;
    rsr_d       = rsr_q;
    sclk_d      = sclk_q;
    sdio_o_d    = sdio_o_q;
    sdio_oe_d   = sdio_oe_q;
    csn_dac_d   = csn_dac_q;
    csn_adc_d   = csn_adc_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_SETUP;
          cnt_d     = CW'(CS_SETUP_CYC - 1);
          bit_d     = '0;
          tgt_d     = cmd_target;
          wsr_d     = cmd_wdata;
          rsr_d     = '0;
          sclk_d    = 1'b0;
          csn_dac_d = cmd_target;
          csn_adc_d = ~cmd_target;
          // ADC frames never drive sdio; the pad belongs to the converter.
          sdio_oe_d = ~cmd_target;
          sdio_o_d  = ~cmd_target & cmd_wdata[DAC_BITS-1];
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = CW'(CLK_DIV - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          cnt_d  = CW'(CLK_DIV - 1);
          if (tgt_q) begin
            rsr_d = {rsr_q[ADC_BITS-2:0], sdio_i};
          end
        end else begin
          // Falling edge: either present the next DAC bit or close the frame.
          sclk_d = 1'b0;
          if (last_bit) begin
            state_d = S_HOLD;
            cnt_d   = CW'(CS_HOLD_CYC - 1);
          end else begin
            bit_d = bit_q + BW'(1);
            cnt_d = CW'(CLK_DIV - 1);
            if (!tgt_q) begin
              wsr_d    = wsr_q << 1;
              sdio_o_d = wsr_d[DAC_BITS-1];
            end
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          csn_dac_d   = 1'b1;
          csn_adc_d   = 1'b1;
          sdio_oe_d   = 1'b0;
          sdio_o_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = tgt_q ? 32'(rsr_q) : 32'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        csn_dac_d = 1'b1;
        csn_adc_d = 1'b1;
        sclk_d    = 1'b0;
        sdio_oe_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tgt_q       <= 1'b0;
      wsr_q       <= '0;
      rsr_q       <= '0;
      sclk_q      <= 1'b0;
      sdio_o_q    <= 1'b0;
      sdio_oe_q   <= 1'b0;
      csn_dac_q   <= 1'b1;
      csn_adc_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tgt_q       <= tgt_d;
      wsr_q       <= wsr_d;
      rsr_q       <= rsr_d;
      sclk_q      <= sclk_d;
      sdio_o_q    <= sdio_o_d;
      sdio_oe_q   <= sdio_oe_d;
      csn_dac_q   <= csn_dac_d;
      csn_adc_q   <= csn_adc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign ni_csn_hp_dac = csn_dac_q;
  assign ni_csn_adc    = csn_adc_q;
  assign ni_sclk       = sclk_q;
  assign sdio_o        = sdio_o_q;
  assign sdio_oe       = sdio_oe_q;

endmodule

// File: tb/tb_nipcb_spi_master.sv
// Bench for nipcb_spi_master: default-parameter instance plus a CLK_DIV=1 / 1-cycle setup/hold instance.
// Responses are scoreboarded; a negedge monitor measures csn widths, sclk edges, DAC bits and drives the ADC slave.
module tb_nipcb_spi_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cmd_valid  [2];
  logic        cmd_ready  [2];
  logic        cmd_target [2];
  logic [23:0] cmd_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        busy       [2];
  logic        csn_dac    [2];
  logic        csn_adc    [2];
  logic        sclk       [2];
  logic        sdio_o     [2];
  logic        sdio_oe    [2];
  logic        sdio_i     [2];

  nipcb_spi_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_target(cmd_target[0]),
    .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .busy(busy[0]), .ni_csn_hp_dac(csn_dac[0]), .ni_csn_adc(csn_adc[0]),
    .ni_sclk(sclk[0]), .sdio_o(sdio_o[0]), .sdio_oe(sdio_oe[0]), .sdio_i(sdio_i[0])
  );

  nipcb_spi_master #(
    .CLK_DIV(1), .DAC_BITS(24), .ADC_BITS(16), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)
  ) dut_fast (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_target(cmd_target[1]),
    .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .busy(busy[1]), .ni_csn_hp_dac(csn_dac[1]), .ni_csn_adc(csn_adc[1]),
    .ni_sclk(sclk[1]), .sdio_o(sdio_o[1]), .sdio_oe(sdio_oe[1]), .sdio_i(sdio_i[1])
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  int          dac_cnt[2], adc_cnt[2], dac_len[2], adc_len[2];
  int          rises[2], high_cnt[2], gap[2], gap_last[2];
  int          rsp_cnt[2], rsp_cyc[2], adc_falls[2];
  logic [31:0] dac_cap[2];
  logic [15:0] sh[2], slave_word[2];
  logic        prev_dac[2], prev_adc[2], prev_sclk[2], prev_rsp[2];
  int          both_low, rdy_busy_bad, busy_bad, adc_oe_bad, dac_oe_bad, multi_rsp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!csn_dac[i] && !csn_adc[i]) both_low++;
        if (cmd_ready[i] == busy[i]) rdy_busy_bad++;
        if ((!csn_dac[i] || !csn_adc[i]) && !busy[i]) busy_bad++;
        if (!csn_adc[i] && sdio_oe[i]) adc_oe_bad++;
        if (!csn_dac[i] && !sdio_oe[i]) dac_oe_bad++;

        if ((!csn_dac[i] && prev_dac[i]) || (!csn_adc[i] && prev_adc[i])) begin
          gap_last[i] = gap[i];
          rises[i]    = 0;
          high_cnt[i] = 0;
        end
        if (!csn_dac[i] && prev_dac[i]) begin
          dac_cap[i] = 32'd0;
          dac_cnt[i] = 0;
        end
        if (!csn_adc[i] && prev_adc[i]) begin
          adc_cnt[i] = 0;
          adc_falls[i]++;
          sh[i]      = slave_word[i];
          sdio_i[i]  = sh[i][15];
        end else if (!csn_adc[i] && !sclk[i] && prev_sclk[i]) begin
          sh[i]     = sh[i] << 1;
          sdio_i[i] = sh[i][15];
        end

        if (!csn_dac[i]) dac_cnt[i]++;
        if (!csn_adc[i]) adc_cnt[i]++;
        if (csn_dac[i] && !prev_dac[i]) dac_len[i] = dac_cnt[i];
        if (csn_adc[i] && !prev_adc[i]) adc_len[i] = adc_cnt[i];
        if (csn_dac[i] && csn_adc[i]) gap[i]++;
        else gap[i] = 0;

        if (sclk[i] && !prev_sclk[i]) begin
          rises[i]++;
          if (!csn_dac[i]) dac_cap[i] = {dac_cap[i][30:0], sdio_o[i]};
        end
        if (sclk[i] && (!csn_dac[i] || !csn_adc[i])) high_cnt[i]++;

        if (rsp_valid[i]) begin
          rsp_cnt[i]++;
          rsp_cyc[i] = cyc;
          if (prev_rsp[i]) multi_rsp++;
          if (i == 0) begin
            if (exp_q0.size() == 0) chk("rsp_unexpected0", 32'(exp_q0.size()), 32'd1);
            else chk("rsp_rdata0", rsp_rdata[0], exp_q0.pop_front());
          end else begin
            if (exp_q1.size() == 0) chk("rsp_unexpected1", 32'(exp_q1.size()), 32'd1);
            else chk("rsp_rdata1", rsp_rdata[1], exp_q1.pop_front());
          end
        end

        prev_dac[i]  = csn_dac[i];
        prev_adc[i]  = csn_adc[i];
        prev_sclk[i] = sclk[i];
        prev_rsp[i]  = rsp_valid[i];
      end
    end
  end

  task automatic push_exp(input int d, input logic tgt, input logic [15:0] sw);
    if (d == 0) exp_q0.push_back(tgt ? 32'(sw) : 32'd0);
    else exp_q1.push_back(tgt ? 32'(sw) : 32'd0);
  endtask

  // Called just after a negedge; returns one cycle after the accepting edge.
  task automatic issue(input int d, input logic tgt, input logic [23:0] w,
                       input logic [15:0] sw, input bit push);
    int n;
    slave_word[d] = sw;
    cmd_target[d] = tgt;
    cmd_wdata[d]  = w;
    cmd_valid[d]  = 1'b1;
    if (push) push_exp(d, tgt, sw);
    n = 0;
    while (!cmd_ready[d] && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) chk("accept_timeout", 32'(n), 32'd0);
    step();
    cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input string tag);
    int r0, n;
    r0 = rsp_cnt[d];
    n  = 0;
    while (rsp_cnt[d] == r0 && n < 3000) begin
      step();
      n++;
    end
    if (rsp_cnt[d] == r0) chk(tag, 32'(rsp_cnt[d] - r0), 32'd1);
    step();
  endtask

  initial begin
    int n, a0, r0, acc_cyc, acc_diff;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_target[i] = 1'b0; cmd_wdata[i] = 24'd0; sdio_i[i] = 1'b0;
      dac_cnt[i] = 0; adc_cnt[i] = 0; dac_len[i] = 0; adc_len[i] = 0;
      rises[i] = 0; high_cnt[i] = 0; gap[i] = 0; gap_last[i] = 0;
      rsp_cnt[i] = 0; rsp_cyc[i] = 0; adc_falls[i] = 0;
      dac_cap[i] = 32'd0; sh[i] = 16'd0; slave_word[i] = 16'd0;
    end
    both_low = 0; rdy_busy_bad = 0; busy_bad = 0; adc_oe_bad = 0; dac_oe_bad = 0; multi_rsp = 0;

    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      prev_dac[i] = csn_dac[i]; prev_adc[i] = csn_adc[i];
      prev_sclk[i] = sclk[i]; prev_rsp[i] = rsp_valid[i];
    end
    mon_en = 1'b1;

    chk("rst_csn_dac", 32'(csn_dac[0]), 32'd1);
    chk("rst_csn_adc", 32'(csn_adc[0]), 32'd1);
    chk("rst_sclk", 32'(sclk[0]), 32'd0);
    chk("rst_sdio_o", 32'(sdio_o[0]), 32'd0);
    chk("rst_sdio_oe", 32'(sdio_oe[0]), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_fast_ready", 32'(cmd_ready[1]), 32'd1);
    reset = 1'b0;
    step();

    // DAC write, default timing
    a0 = adc_falls[0];
    issue(0, 1'b0, 24'hA5C3F0, 16'h0000, 1'b1);
    chk("dac_busy", 32'(busy[0]), 32'd1);
    chk("dac_ready_low", 32'(cmd_ready[0]), 32'd0);
    wait_rsp(0, "dac_rsp_timeout");
    chk("dac_csn_len", 32'(dac_len[0]), 32'd196);
    chk("dac_rises", 32'(rises[0]), 32'd24);
    chk("dac_high_cyc", 32'(high_cnt[0]), 32'd96);
    chk("dac_bits", dac_cap[0], 32'h00A5C3F0);
    chk("dac_adc_csn_idle", 32'(adc_falls[0] - a0), 32'd0);

    // ADC read, default timing
    issue(0, 1'b1, 24'h000000, 16'hBEEF, 1'b1);
    wait_rsp(0, "adc_rsp_timeout");
    chk("adc_csn_len", 32'(adc_len[0]), 32'd132);
    chk("adc_rises", 32'(rises[0]), 32'd16);
    chk("adc_high_cyc", 32'(high_cnt[0]), 32'd64);
    chk("adc_oe_driven", 32'(adc_oe_bad), 32'd0);

    // Back-to-back with cmd_valid held: DAC then ADC
    slave_word[0] = 16'h5A3C;
    cmd_target[0] = 1'b0;
    cmd_wdata[0]  = 24'h3C5A96;
    cmd_valid[0]  = 1'b1;
    push_exp(0, 1'b0, 16'h0000);
    n = 0;
    while (!cmd_ready[0] && n < 1000) begin step(); n++; end
    step();
    cmd_target[0] = 1'b1;
    cmd_wdata[0]  = 24'hFFFFFF;
    push_exp(0, 1'b1, 16'h5A3C);
    n = 0;
    while (!cmd_ready[0] && n < 1000) begin step(); n++; end
    if (n >= 1000) chk("b2b_accept_timeout", 32'(n), 32'd0);
    acc_cyc  = cyc;
    acc_diff = acc_cyc - rsp_cyc[0];
    step();
    cmd_valid[0] = 1'b0;
    chk("b2b_accept_after_rsp", 32'(acc_diff), 32'd1);
    wait_rsp(0, "b2b_rsp_timeout");
    chk("b2b_dac_bits", dac_cap[0], 32'h003C5A96);
    chk("b2b_dac_len", 32'(dac_len[0]), 32'd196);
    chk("b2b_adc_len", 32'(adc_len[0]), 32'd132);
    chk("b2b_csn_gap_ge2", 32'(gap_last[0] >= 2), 32'd1);

    // Reset at the 10th sclk rise of a DAC frame
    issue(0, 1'b0, 24'h0F0F0F, 16'h0000, 1'b0);
    n = 0;
    while (rises[0] < 10 && n < 2000) begin step(); n++; end
    if (rises[0] < 10) chk("rise10_timeout", 32'(rises[0]), 32'd10);
    r0 = rsp_cnt[0];
    reset = 1'b1;
    step();
    chk("mrst_csn_dac", 32'(csn_dac[0]), 32'd1);
    chk("mrst_csn_adc", 32'(csn_adc[0]), 32'd1);
    chk("mrst_sclk", 32'(sclk[0]), 32'd0);
    chk("mrst_sdio_oe", 32'(sdio_oe[0]), 32'd0);
    chk("mrst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("mrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mrst_rsp_rdata", rsp_rdata[0], 32'd0);
    cmd_target[0] = 1'b1;
    cmd_valid[0]  = 1'b1;
    step();
    chk("rst_vs_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst_vs_cmd_busy", 32'(busy[0]), 32'd0);
    reset = 1'b0;
    cmd_valid[0] = 1'b0;
    step();
    chk("rst_vs_cmd_csn_adc", 32'(csn_adc[0]), 32'd1);
    chk("mrst_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);

    issue(0, 1'b1, 24'h000000, 16'hC0DE, 1'b1);
    wait_rsp(0, "post_rst_rsp_timeout");
    chk("post_rst_adc_len", 32'(adc_len[0]), 32'd132);

    // Fast instance: sclk toggles every cycle
    issue(1, 1'b1, 24'h000000, 16'h8001, 1'b1);
    wait_rsp(1, "fast_adc_rsp_timeout");
    chk("fast_adc_len", 32'(adc_len[1]), 32'd34);
    chk("fast_adc_rises", 32'(rises[1]), 32'd16);
    chk("fast_adc_high_cyc", 32'(high_cnt[1]), 32'd16);
    issue(1, 1'b0, 24'h800001, 16'h0000, 1'b1);
    wait_rsp(1, "fast_dac_rsp_timeout");
    chk("fast_dac_len", 32'(dac_len[1]), 32'd50);
    chk("fast_dac_bits", dac_cap[1], 32'h00800001);

    repeat (4) step();
    chk("never_both_csn_low", 32'(both_low), 32'd0);
    chk("ready_busy_complement", 32'(rdy_busy_bad), 32'd0);
    chk("busy_while_csn_low", 32'(busy_bad), 32'd0);
    chk("adc_oe_never", 32'(adc_oe_bad), 32'd0);
    chk("dac_oe_held", 32'(dac_oe_bad), 32'd0);
    chk("rsp_single_pulse", 32'(multi_rsp), 32'd0);
    chk("sb0_drained", 32'(exp_q0.size()), 32'd0);
    chk("sb1_drained", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
